// File: rtl/ev22_isa_pkg.sv
// Shared EV22 instruction-set constants: branch-unit opcode encodings (B13..B11)
// and the condition test used by the conditional jumps.
package ev22_isa_pkg;

  localparam logic [2:0] OP_RET  = 3'b000;
  localparam logic [2:0] OP_NOP1 = 3'b001;
  localparam logic [2:0] OP_NOP2 = 3'b010;
  localparam logic [2:0] OP_BSR  = 3'b011;
  localparam logic [2:0] OP_JMP  = 3'b100;
  localparam logic [2:0] OP_JZE  = 3'b101;
  localparam logic [2:0] OP_JNE  = 3'b110;
  localparam logic [2:0] OP_JCY  = 3'b111;

  // Jump condition for the JMP/JZE/JNE/JCY group; 0 for every other opcode.
  function automatic logic jump_cond(input logic [2:0] op, input logic cy,
                                     input logic w_neg, input logic w_zero);
    logic r;
    r = 1'b0;
    case (op)
      OP_JMP:  r = 1'b1;
      OP_JZE:  r = w_zero;
      OP_JNE:  r = w_neg;
      OP_JCY:  r = cy;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ret_stack.sv
// Return-address LIFO. Push is ignored when full, pop is ignored when empty;
// the owner detects those cases through full_o/empty_o.
module ret_stack #(
  parameter int ADDR_W      = 11,
  parameter int STACK_DEPTH = 4,
  localparam int SP_W       = $clog2(STACK_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [ADDR_W-1:0] data_i,
  output logic [ADDR_W-1:0] data_o,
  output logic [SP_W-1:0]   sp_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [ADDR_W-1:0] mem_q [STACK_DEPTH];
  logic [SP_W-1:0]   sp_q, sp_d;
  logic [IDX_W-1:0]  wr_idx, rd_idx;
  logic              do_push, do_pop;

  assign full_o  = (sp_q == SP_W'(STACK_DEPTH));
  assign empty_o = (sp_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign wr_idx  = IDX_W'(sp_q);
  assign rd_idx  = IDX_W'(sp_q - 1'b1);
  assign sp_o    = sp_q;

  // Masked when empty so stale entries never leak out.
  assign data_o = empty_o ? '0 : mem_q[rd_idx];

  always_comb begin
    sp_d = sp_q;
    if (do_push)     sp_d = sp_q + 1'b1;
    else if (do_pop) sp_d = sp_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sp_q <= '0;
    else        sp_q <= sp_d;
  end

  // Entry storage is deliberately not reset; sp alone defines what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_idx] <= data_i;
  end

endmodule

// File: rtl/pc_branch_unit.sv
// EV22 program counter with conditional jumps, subroutine call/return through
// ret_stack, and sticky stack overflow/underflow flags.
module pc_branch_unit
  import ev22_isa_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 11,
  parameter int STACK_DEPTH = 4,
  parameter int RESET_PC    = 0,
  localparam int SP_W       = $clog2(STACK_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [2:0]        opcode,
  input  logic [ADDR_W-1:0] target,
  input  logic              cy,
  input  logic [DATA_W-1:0] w,
  input  logic              clr_err,
  output logic [ADDR_W-1:0] pc,
  output logic              taken,
  output logic [SP_W-1:0]   sp,
  output logic              stack_ovf,
  output logic              stack_unf
);

  localparam logic [ADDR_W-1:0] RESET_PC_V = ADDR_W'(RESET_PC);

  logic [ADDR_W-1:0] pc_q, pc_d, seq_pc, stk_top;
  logic              taken_q, taken_d;
  logic              ovf_q, ovf_d, unf_q, unf_d;
  logic              push, pop, ovf_set, unf_set;
  logic              stk_full, stk_empty;

  ret_stack #(
    .ADDR_W      (ADDR_W),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (seq_pc),
    .data_o  (stk_top),
    .sp_o    (sp),
    .full_o  (stk_full),
    .empty_o (stk_empty)
  );

  assign seq_pc = pc_q + 1'b1;

  // Next-PC selection; everything here is qualified by en so a stalled step
  // touches neither the stack nor the error flags.
  always_comb begin
    pc_d    = seq_pc;
    taken_d = 1'b0;
    push    = 1'b0;
    pop     = 1'b0;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    if (en) begin
      case (opcode)
        OP_BSR: begin
          if (stk_full) begin
            ovf_set = 1'b1;
          end else begin
            push    = 1'b1;
            pc_d    = target;
            taken_d = 1'b1;
          end
        end
        OP_RET: begin
          if (stk_empty) begin
            unf_set = 1'b1;
          end else begin
            pop     = 1'b1;
            pc_d    = stk_top;
            taken_d = 1'b1;
          end
        end
        default: begin
          if (jump_cond(opcode, cy, w[DATA_W-1], (w == '0))) begin
            pc_d    = target;
            taken_d = 1'b1;
          end
        end
      endcase
    end
  end

  // A flag raised in the same cycle as clr_err stays set.
  assign ovf_d = ovf_set | (ovf_q & ~clr_err);
  assign unf_d = unf_set | (unf_q & ~clr_err);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC_V;
      taken_q <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      if (en) pc_q <= pc_d;
      taken_q <= taken_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign pc        = pc_q;
  assign taken     = taken_q;
  assign stack_ovf = ovf_q;
  assign stack_unf = unf_q;

endmodule

// File: tb/tb_pc_branch_unit.sv
// Directed bench for pc_branch_unit: expected state is queued with each step
// and compared one cycle later against {pc, taken, sp, stack_ovf, stack_unf}.
module tb_pc_branch_unit;
  import ev22_isa_pkg::*;

  localparam int DATA_W      = 16;
  localparam int ADDR_W      = 11;
  localparam int STACK_DEPTH = 4;
  localparam int SP_W        = $clog2(STACK_DEPTH + 1);
  localparam int W           = ADDR_W + 1 + SP_W + 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              en;
  logic [2:0]        opcode;
  logic [ADDR_W-1:0] target;
  logic              cy;
  logic [DATA_W-1:0] w;
  logic              clr_err;
  logic [ADDR_W-1:0] pc;
  logic              taken;
  logic [SP_W-1:0]   sp;
  logic              stack_ovf;
  logic              stack_unf;

  logic [W-1:0] exp_q[$];
  int vectors     = 0;
  int miscompares = 0;

  pc_branch_unit #(
    .DATA_W      (DATA_W),
    .ADDR_W      (ADDR_W),
    .STACK_DEPTH (STACK_DEPTH),
    .RESET_PC    (0)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .opcode    (opcode),
    .target    (target),
    .cy        (cy),
    .w         (w),
    .clr_err   (clr_err),
    .pc        (pc),
    .taken     (taken),
    .sp        (sp),
    .stack_ovf (stack_ovf),
    .stack_unf (stack_unf)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Scoreboard
  task automatic push_exp(input logic [ADDR_W-1:0] xpc, input logic xt,
                          input logic [SP_W-1:0] xsp, input logic xo, input logic xu);
    exp_q.push_back({xpc, xt, xsp, xo, xu});
  endtask

  task automatic compare(input string tag);
    logic [W-1:0] obs;
    logic [W-1:0] exp_v;
    obs = {pc, taken, sp, stack_ovf, stack_unf};
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $error("FAIL %s observed=%h expected=<empty queue>", tag, obs);
    end else begin
      exp_v = exp_q.pop_front();
      assert (obs === exp_v) else begin
        miscompares++;
        $error("FAIL %s observed pc=%h taken=%b sp=%0d ovf=%b unf=%b expected pc=%h taken=%b sp=%0d ovf=%b unf=%b",
               tag, obs[W-1 -: ADDR_W], obs[SP_W+2], obs[SP_W+1:2], obs[1], obs[0],
               exp_v[W-1 -: ADDR_W], exp_v[SP_W+2], exp_v[SP_W+1:2], exp_v[1], exp_v[0]);
      end
    end
  endtask

  // Driver
  task automatic step(input logic e, input logic [2:0] op, input logic [ADDR_W-1:0] tg,
                      input logic c, input logic [DATA_W-1:0] wv, input logic clr,
                      input logic [ADDR_W-1:0] xpc, input logic xt, input logic [SP_W-1:0] xsp,
                      input logic xo, input logic xu, input string tag);
    @(negedge clk);
    en      = e;
    opcode  = op;
    target  = tg;
    cy      = c;
    w       = wv;
    clr_err = clr;
    push_exp(xpc, xt, xsp, xo, xu);
    @(posedge clk);
    #1;
    compare(tag);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; opcode = OP_NOP1; target = '0;
    cy = 1'b0; w = '0; clr_err = 1'b0;
    #1;
    push_exp(11'h000, 1'b0, 3'd0, 1'b0, 1'b0);
    compare("reset_async");
    repeat (2) @(posedge clk);
    #1;
    push_exp(11'h000, 1'b0, 3'd0, 1'b0, 1'b0);
    compare("reset_held");
    @(negedge clk);
    rst_n = 1'b1;

    // Sequential stepping and en=0 hold
    step(1, OP_NOP1, 11'h7AA, 0, 16'h1234, 0, 11'h001, 0, 3'd0, 0, 0, "nop_1");
    step(1, OP_NOP1, 11'h155, 1, 16'h0000, 0, 11'h002, 0, 3'd0, 0, 0, "nop_2");
    step(1, OP_NOP2, 11'h000, 0, 16'hFFFF, 0, 11'h003, 0, 3'd0, 0, 0, "nop_3");
    step(0, OP_JMP,  11'h3C0, 1, 16'h0000, 0, 11'h003, 0, 3'd0, 0, 0, "en_low_hold");

    // Conditional jumps
    step(1, OP_JMP, 11'h005, 0, 16'h0001, 0, 11'h005, 1, 3'd0, 0, 0, "jmp_5");
    step(1, OP_JZE, 11'h040, 0, 16'h0000, 0, 11'h040, 1, 3'd0, 0, 0, "jze_taken");
    step(1, OP_JZE, 11'h040, 1, 16'h0001, 0, 11'h041, 0, 3'd0, 0, 0, "jze_not");
    step(1, OP_JMP, 11'h010, 0, 16'h0000, 0, 11'h010, 1, 3'd0, 0, 0, "jmp_10");
    step(1, OP_JNE, 11'h020, 0, 16'h8000, 0, 11'h020, 1, 3'd0, 0, 0, "jne_taken");
    step(1, OP_JCY, 11'h050, 0, 16'h8000, 0, 11'h021, 0, 3'd0, 0, 0, "jcy_not");
    step(1, OP_JCY, 11'h030, 1, 16'h0000, 0, 11'h030, 1, 3'd0, 0, 0, "jcy_taken");
    step(1, OP_JNE, 11'h060, 1, 16'h7FFF, 0, 11'h031, 0, 3'd0, 0, 0, "jne_not");
    step(1, OP_NOP2, 11'h060, 1, 16'h0000, 0, 11'h032, 0, 3'd0, 0, 0, "nop2_seq");

    // Nested subroutines, overflow, returns
    step(1, OP_JMP, 11'h100, 0, 16'h0, 0, 11'h100, 1, 3'd0, 0, 0, "jmp_100");
    step(1, OP_BSR, 11'h200, 0, 16'h0, 0, 11'h200, 1, 3'd1, 0, 0, "bsr_1");
    step(1, OP_BSR, 11'h300, 0, 16'h0, 0, 11'h300, 1, 3'd2, 0, 0, "bsr_2");
    step(1, OP_BSR, 11'h400, 0, 16'h0, 0, 11'h400, 1, 3'd3, 0, 0, "bsr_3");
    step(1, OP_BSR, 11'h500, 0, 16'h0, 0, 11'h500, 1, 3'd4, 0, 0, "bsr_4");
    step(1, OP_BSR, 11'h600, 0, 16'h0, 0, 11'h501, 0, 3'd4, 1, 0, "bsr_ovf");
    step(1, OP_RET, 11'h000, 0, 16'h0, 0, 11'h401, 1, 3'd3, 1, 0, "ret_1");
    step(1, OP_RET, 11'h000, 0, 16'h0, 0, 11'h301, 1, 3'd2, 1, 0, "ret_2");
    step(1, OP_RET, 11'h000, 0, 16'h0, 0, 11'h201, 1, 3'd1, 1, 0, "ret_3");
    step(1, OP_RET, 11'h000, 0, 16'h0, 0, 11'h101, 1, 3'd0, 1, 0, "ret_4");

    // Underflow and clear priority
    step(1, OP_RET, 11'h000, 0, 16'h0, 0, 11'h102, 0, 3'd0, 1, 1, "ret_unf");
    step(1, OP_RET, 11'h000, 0, 16'h0, 1, 11'h103, 0, 3'd0, 0, 1, "clr_vs_unf");
    step(0, OP_RET, 11'h000, 0, 16'h0, 1, 11'h103, 0, 3'd0, 0, 0, "clr_alone");

    // PC wrap, then asynchronous reset with returns pending
    step(1, OP_JMP,  11'h7FF, 0, 16'h0, 0, 11'h7FF, 1, 3'd0, 0, 0, "jmp_7ff");
    step(1, OP_NOP1, 11'h000, 0, 16'h0, 0, 11'h000, 0, 3'd0, 0, 0, "pc_wrap");
    step(1, OP_BSR,  11'h010, 0, 16'h0, 0, 11'h010, 1, 3'd1, 0, 0, "bsr_a");
    step(1, OP_BSR,  11'h020, 0, 16'h0, 0, 11'h020, 1, 3'd2, 0, 0, "bsr_b");
    en = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    push_exp(11'h000, 1'b0, 3'd0, 1'b0, 1'b0);
    compare("reset_mid");
    @(negedge clk);
    rst_n = 1'b1;
    step(1, OP_NOP1, 11'h000, 0, 16'h0, 0, 11'h001, 0, 3'd0, 0, 0, "post_reset");
    step(1, OP_RET,  11'h000, 0, 16'h0, 0, 11'h002, 0, 3'd0, 0, 1, "post_reset_ret");

    en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pc_branch_unit.md
PC_BRANCH_UNIT -- requirements
Module: pc_branch_unit

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, the width of the W accumulator used for sign and zero tests.
REQ-002 The block SHALL have parameter ADDR_W, default 11, the program-counter and branch-target width.
REQ-003 The block SHALL have parameter STACK_DEPTH, default 4 (>=1), the number of return-address entries.
REQ-004 The block SHALL have parameter RESET_PC, default 0, the PC value after reset.
REQ-005 The block SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-007 The block SHALL have port en  input  1  instruction-step strobe; state advances only when high.
REQ-008 The block SHALL have port opcode  input  3  instruction bits B13..B11.
REQ-009 The block SHALL have port target  input  ADDR_W  branch/subroutine address from the instruction.
REQ-010 The block SHALL have port cy  input  1  carry flag.
REQ-011 The block SHALL have port w  input  DATA_W  accumulator value.
REQ-012 The block SHALL have port clr_err  input  1  clears the sticky error flags.
REQ-013 The block SHALL have port pc  output  ADDR_W  registered program counter.
REQ-014 The block SHALL have port taken  output  1  registered; high for one cycle after a step that loaded a non-sequential PC.
REQ-015 The block SHALL have port sp  output  $clog2(STACK_DEPTH+1)  current stack occupancy.
REQ-016 The block SHALL have port stack_ovf  output  1  sticky; set by a push when the stack is full.
REQ-017 The block SHALL have port stack_unf  output  1  sticky; set by a pop when the stack is empty.

Function
REQ-018 When en=0, pc, sp and the stack SHALL hold, and taken SHALL be 0 on the next cycle.
REQ-019 On an en=1 edge, pc SHALL be loaded from next_pc; latency is one clock.
REQ-020 Sequential next_pc SHALL be (pc+1) mod 2^ADDR_W; 2^ADDR_W-1 wraps to 0.
REQ-021 opcode 111 (JCY) SHALL set next_pc=target if cy=1, else sequential.
REQ-022 opcode 110 (JNE) SHALL set next_pc=target if w[DATA_W-1]=1, else sequential.
REQ-023 opcode 101 (JZE) SHALL set next_pc=target if w==0, else sequential.
REQ-024 opcode 100 (JMP) SHALL set next_pc=target unconditionally.
REQ-025 opcode 011 (BSR) with sp<STACK_DEPTH SHALL push sequential pc+1, increment sp, and set next_pc=target.
REQ-026 opcode 011 with sp==STACK_DEPTH SHALL leave the stack and sp unchanged, set stack_ovf, and take next_pc sequential.
REQ-027 opcode 000 (RET) with sp>0 SHALL pop the top entry into next_pc and decrement sp.
REQ-028 opcode 000 with sp==0 SHALL set stack_unf and take next_pc sequential.
REQ-029 opcodes 001 and 010 SHALL be non-branching: next_pc sequential, stack untouched.
REQ-030 taken SHALL be 1 exactly when next_pc came from target or the stack.
REQ-031 clr_err=1 SHALL clear both sticky flags; an error raised in the same cycle SHALL win, leaving that flag set.
REQ-032 Inputs SHALL be sampled only on en=1 edges; opcode, target, cy and w are don't-care otherwise.

Reset
REQ-033 Asserting rst_n low SHALL immediately force pc=RESET_PC, sp=0, taken=0, stack_ovf=0 and stack_unf=0, regardless of clk.
REQ-034 Stack entry contents need not be reset; entries above sp SHALL never be observable.
REQ-035 Reset asserted mid-sequence SHALL discard all pending returns; the first step after release SHALL execute from RESET_PC.

Structure
REQ-036 Opcode encodings SHALL be named constants in shared package ev22_isa_pkg, for reuse by decode and the assembler-facing testbench.
REQ-037 The LIFO SHALL be a sub-module ret_stack (parameters ADDR_W, STACK_DEPTH; push, pop, data in/out, sp, full, empty).
REQ-038 Branch-condition evaluation SHALL be combinational; pc, taken, sp and the flags SHALL be the only registered outputs.

Verification
REQ-039 Reset, then en with 001 three times -> pc 0,1,2,3; taken stays 0.
REQ-040 pc=5, JZE target=0x40 with w=0 -> pc=0x40, taken=1; repeat with w=0x0001 -> pc=0x41, taken=0.
REQ-041 pc=0x10, JNE target=0x20 with w=0x8000 -> pc=0x20; JCY with cy=0 -> pc=0x21.
REQ-042 STACK_DEPTH=4: five BSRs from pc=0x100,0x200,0x300,0x400,0x500 (target=pc+0x100), then four RETs -> fifth BSR sets stack_ovf, pc=0x501; RETs return 0x401,0x301,0x201,0x101; sp=0.
REQ-043 sp=0, RET -> stack_unf=1, pc=pc+1; assert clr_err together with a second empty RET -> stack_unf stays 1; clr_err alone -> 0.
REQ-044 pc=0x7FF with ADDR_W=11, opcode 001 -> pc=0x000; assert rst_n low between clock edges with sp=2 -> pc=RESET_PC and sp=0 without waiting for a clock edge.
